// File: rtl/sub_seq_ctrl_pkg.sv
// Shared types and constants for the multi-byte subtract sequencer.
package sub_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        CMD_LOAD_A = 2'd0,
        CMD_LOAD_B = 2'd1,
        CMD_START  = 2'd2,
        CMD_READ   = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/sub_seq_ctrl_if.sv
// Command bus and result/status signals between pin decode and the sequencer.
interface sub_seq_ctrl_if;
    import sub_pkg::*;

    logic              cmd_valid;
    cmd_op_e           cmd_op;
    logic [BYTE_W-1:0] din;
    logic              cmd_ready;
    logic [BYTE_W-1:0] dout;
    logic              dout_valid;
    logic              busy;
    logic              done;
    logic              borrow_out;

    modport master (
        output cmd_valid, cmd_op, din,
        input  cmd_ready, dout, dout_valid, busy, done, borrow_out
    );

    modport slave (
        input  cmd_valid, cmd_op, din,
        output cmd_ready, dout, dout_valid, busy, done, borrow_out
    );

endinterface

// File: rtl/sub_byte_alu.sv
// Shared byte-wide subtract-with-borrow unit: {bout, diff} = a - b - bin.
module sub_byte_alu
    import sub_pkg::*;
(
    input  logic [BYTE_W-1:0] i_a,
    input  logic [BYTE_W-1:0] i_b,
    input  logic              i_bin,
    output logic [BYTE_W-1:0] o_diff,
    output logic              o_bout
);

    // Nine-bit difference: the top bit goes high exactly when the byte underflows.
    assign {o_bout, o_diff} = {1'b0, i_a} - {1'b0, i_b} - {{BYTE_W{1'b0}}, i_bin};

endmodule

// File: rtl/sub_seq_ctrl.sv
// Byte-serial NBYTES-wide unsigned subtract sequencer around one shared byte ALU.
// Optional macro SUB_SAT_EN: saturate readout to zero when the result borrowed.
module sub_seq_ctrl
    import sub_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int PTR_W  = $clog2(NBYTES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    sub_seq_ctrl_if.slave bus
);

    localparam logic [1:0]       S_IDLE    = 2'(ST_IDLE);
    localparam logic [1:0]       S_COMPUTE = 2'(ST_COMPUTE);
    localparam logic [1:0]       S_DONE    = 2'(ST_DONE);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NBYTES - 1);

    logic [1:0]        r_state;
    logic [BYTE_W-1:0] r_a [NBYTES];
    logic [BYTE_W-1:0] r_b [NBYTES];
    logic [BYTE_W-1:0] r_r [NBYTES];
    logic [PTR_W-1:0]  r_a_ptr;
    logic [PTR_W-1:0]  r_b_ptr;
    logic [PTR_W-1:0]  r_r_ptr;
    logic [PTR_W-1:0]  r_idx;
    logic              r_carry;
    logic              r_borrow_out;
    logic              r_done;
    logic              r_dout_valid;
    logic [BYTE_W-1:0] r_dout;

    logic              w_cmd_ready;
    logic              w_fire;
    logic              w_load_a;
    logic              w_load_b;
    logic              w_start;
    logic              w_read;
    logic [BYTE_W-1:0] w_diff;
    logic              w_bout;
    logic [BYTE_W-1:0] w_rd_byte;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_cmd_ready = ena & (r_state != S_COMPUTE);
    assign w_fire      = bus.cmd_valid & w_cmd_ready;
    assign w_load_a    = w_fire & (bus.cmd_op == CMD_LOAD_A);
    assign w_load_b    = w_fire & (bus.cmd_op == CMD_LOAD_B);
    assign w_start     = w_fire & (bus.cmd_op == CMD_START);
    assign w_read      = w_fire & (bus.cmd_op == CMD_READ);

    sub_byte_alu u_alu (
        .i_a    (r_a[r_idx]),
        .i_b    (r_b[r_idx]),
        .i_bin  (r_carry),
        .o_diff (w_diff),
        .o_bout (w_bout)
    );

`ifdef SUB_SAT_EN
    // R keeps the wrap-around value; the clamp to zero happens only on the way out.
    assign w_rd_byte = r_borrow_out ? '0 : r_r[r_r_ptr];
`else
    assign w_rd_byte = r_r[r_r_ptr];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            // NOTE: operand/result byte arrays are small flops, so they take the async reset too.
            for (int i = 0; i < NBYTES; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
                r_r[i] <= '0;
            end
            r_a_ptr      <= '0;
            r_b_ptr      <= '0;
            r_r_ptr      <= '0;
            r_idx        <= '0;
            r_carry      <= 1'b0;
            r_borrow_out <= 1'b0;
            r_done       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout       <= '0;
        end else if (!ena) begin
            r_done       <= 1'b0;
            r_dout_valid <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_dout_valid <= 1'b0;

            // Loads and START behave the same in IDLE and DONE; w_fire already excludes COMPUTE.
            if (w_load_a) begin
                r_a[r_a_ptr] <= bus.din;
                r_a_ptr      <= ptr_inc(r_a_ptr);
            end
            if (w_load_b) begin
                r_b[r_b_ptr] <= bus.din;
                r_b_ptr      <= ptr_inc(r_b_ptr);
            end
            if (w_start) begin
                r_idx        <= '0;
                r_carry      <= 1'b0;
                r_a_ptr      <= '0;
                r_b_ptr      <= '0;
                r_r_ptr      <= '0;
                r_borrow_out <= 1'b0;
                r_state      <= S_COMPUTE;
            end

            case (r_state)
                S_IDLE: begin
                end
                S_COMPUTE: begin
                    r_r[r_idx] <= w_diff;
                    r_carry    <= w_bout;
                    r_idx      <= ptr_inc(r_idx);
                    if (r_idx == LAST_PTR) begin
                        r_borrow_out <= w_bout;
                        r_done       <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (w_read) begin
                        r_dout       <= w_rd_byte;
                        r_dout_valid <= 1'b1;
                        r_r_ptr      <= ptr_inc(r_r_ptr);
                    end
                    if (w_load_a || w_load_b) begin
                        r_r_ptr <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid & ena;
    assign bus.busy       = (r_state == S_COMPUTE);
    assign bus.done       = r_done & ena;
    assign bus.borrow_out = r_borrow_out;

endmodule
